// File: rtl/inst_prefetch_queue_if.sv
// inst_prefetch_queue_if: imem request/response, redirect and decode-side signals of the prefetch queue
interface inst_prefetch_queue_if #(
    parameter int XLEN = 32
);
    logic            imem_req_valid;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_req_ready;
    logic            imem_rsp_valid;
    logic [XLEN-1:0] imem_rsp_data;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            dec_valid;
    logic [XLEN-1:0] dec_instr;
    logic [XLEN-1:0] dec_pc;
    logic [6:0]      dec_op;
    logic [4:0]      dec_func5;
    logic            dec_ready;
    logic            q_empty;
    logic            q_full;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
        input  redirect_valid, redirect_pc,
        output dec_valid, dec_instr, dec_pc, dec_op, dec_func5,
        input  dec_ready,
        output q_empty, q_full
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
        output redirect_valid, redirect_pc,
        input  dec_valid, dec_instr, dec_pc, dec_op, dec_func5,
        output dec_ready,
        input  q_empty, q_full
    );
endinterface

// File: rtl/inst_prefetch_queue.sv
// inst_prefetch_queue: instruction fetch front-end buffering imem words in a DEPTH-entry FIFO with redirect flush
module inst_prefetch_queue #(
    parameter int              DEPTH    = 4,
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input logic                   clk,
    input logic                   rst_n,
    inst_prefetch_queue_if.master bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [XLEN-1:0] NOP = XLEN'(32'h0000_0013);

    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] instr_mem [DEPTH];
    logic [XLEN-1:0] pc_mem [DEPTH];
    logic [XLEN-1:0] side_pc [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr, side_wr, side_rd;
    logic [CW-1:0]   count, outstanding, drop_cnt;
    logic [CW:0]     credit;
    logic            run, accept, rsp, push, pop;

    // run holds requests off until the first clock after reset release, without gating on rst_n itself
    assign credit             = {1'b0, count} + {1'b0, outstanding};
    assign bus.imem_req_valid = run && !bus.redirect_valid && (credit < (CW+1)'(DEPTH));
    assign bus.imem_req_addr  = fetch_pc;
    assign accept             = bus.imem_req_valid && bus.imem_req_ready;
    assign rsp                = bus.imem_rsp_valid;
    assign push               = rsp && drop_cnt == '0 && !bus.redirect_valid && !bus.q_full;
    assign pop                = bus.dec_valid && bus.dec_ready && !bus.redirect_valid;
    assign bus.dec_valid      = count != '0;
    assign bus.q_empty        = count == '0;
    assign bus.q_full         = count == CW'(DEPTH);
    assign bus.dec_instr      = bus.dec_valid ? instr_mem[rd_ptr] : NOP;
    assign bus.dec_pc         = bus.dec_valid ? pc_mem[rd_ptr] : '0;
    assign bus.dec_op         = bus.dec_instr[6:0];
    assign bus.dec_func5      = bus.dec_instr[31:27];

    // fetch PC, FIFO pointers and counters; redirect overrides every other event in its cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run         <= 1'b0;
            fetch_pc    <= RESET_PC;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            side_wr     <= '0;
            side_rd     <= '0;
            count       <= '0;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            run         <= 1'b1;
            side_wr     <= side_wr + AW'(accept);
            side_rd     <= side_rd + AW'(rsp);
            outstanding <= outstanding + CW'(accept) - CW'(rsp);
            if (bus.redirect_valid) begin
                fetch_pc <= {bus.redirect_pc[XLEN-1:2], 2'b00};
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                count    <= '0;
                drop_cnt <= outstanding - CW'(rsp);
            end else begin
                if (accept) fetch_pc <= fetch_pc + XLEN'(4);
                wr_ptr   <= wr_ptr + AW'(push);
                rd_ptr   <= rd_ptr + AW'(pop);
                count    <= count + CW'(push) - CW'(pop);
                drop_cnt <= drop_cnt - CW'(rsp && drop_cnt != '0);
            end
        end
    end

    // storage needs no reset: count says which entries are live, side PCs pair with responses in order
    always_ff @(posedge clk) begin
        if (accept) side_pc[side_wr] <= fetch_pc;
        if (push) begin
            instr_mem[wr_ptr] <= bus.imem_rsp_data;
            pc_mem[wr_ptr]    <= side_pc[side_rd];
        end
    end

    // credit accounting makes a kept response into a full queue impossible
    assert property (@(posedge clk) disable iff (!rst_n)
        !(rsp && drop_cnt == '0 && !bus.redirect_valid && bus.q_full));
endmodule
